ctu_jtag_nstep_ctl: RTL and testbench

//  JTAG-side initiator for the CTU n-step clock facility. Owns the NSTEP test data register:

---
 rtl/ctu_jtag_nstep_ctl_pkg.sv | 37 +++
 rtl/ctu_jtag_nstep_ctl_if.sv | 25 ++
 rtl/ctu_jtag_nstep_ctl_sync.sv | 29 ++
 rtl/ctu_jtag_nstep_ctl.sv | 191 +++++++++++++++++++
 tb/tb_ctu_jtag_nstep_ctl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctu_jtag_nstep_ctl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctu_nstep_pkg
//  Description : Shared types and NSTEP data-register field positions.
//  Revision    : 1.0  initial release
// ============================================================================
package ctu_nstep_pkg;

    localparam int c_dr_w = 10;

    // Update-DR field positions
    localparam int c_dr_go     = 9;
    localparam int c_dr_abort  = 8;
    localparam int c_dr_dom_hi = 7;
    localparam int c_dr_dom_lo = 5;
    localparam int c_dr_cnt_hi = 4;
    localparam int c_dr_cnt_lo = 1;

    // Domain mask bit indices
    localparam int c_dom_cmp  = 0;
    localparam int c_dom_dram = 1;
    localparam int c_dom_jbus = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ARM        = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_DONE       = 3'd4
    } nstep_state_e;

    function automatic logic is_busy(input nstep_state_e st);
        return (st == ST_ARM) || (st == ST_WAIT_START) || (st == ST_WAIT_DONE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctu_jtag_nstep_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ctu_jtag_nstep_ctl_if
//  Description : TAP-side data-register access bundle for the NSTEP DR.
//  Revision    : 1.0  initial release
// ============================================================================
interface ctu_jtag_nstep_ctl_if;
    logic sel_nstep;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic tdi;
    logic tdo;

    modport master (
        output sel_nstep, capture_dr, shift_dr, update_dr, tdi,
        input  tdo
    );

    modport slave (
        input  sel_nstep, capture_dr, shift_dr, update_dr, tdi,
        output tdo
    );
endinterface
`default_nettype wire

// File: rtl/ctu_jtag_nstep_ctl_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ctu_nstep_sync
//  Description : STAGES-deep single-bit synchronizer with async reset.
//  Revision    : 1.0  initial release
// ============================================================================
module ctu_nstep_sync #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d,
    output logic      q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ctu_jtag_nstep_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : ctu_jtag_nstep_ctl
//  Description : JTAG-side NSTEP DR owner; issues n-step requests to clkgn
//                and tracks the per-domain nstep_sel handshake to completion.
//  Revision    : 1.0  initial release
// ============================================================================
module ctu_jtag_nstep_ctl
    import ctu_nstep_pkg::*;
#(
    parameter int DR_W        = c_dr_w,
    parameter int SYNC_STAGES = 2,
    parameter int TMO_W       = 12
) (
    input  wire logic           clk,
    input  wire logic           rst,
    ctu_jtag_nstep_ctl_if.slave tap,
    input  wire logic           cmp_nstep_sel,
    input  wire logic           dram_nstep_sel,
    input  wire logic           jbus_nstep_sel,
    output logic [3:0]          jtag_nstep_count,
    output logic [2:0]          jtag_nstep_domain,
    output logic                jtag_nstep_vld,
    output logic                nstep_busy
);

    localparam logic [TMO_W-1:0] c_tmo_max  = '1;
    localparam logic [TMO_W-1:0] c_tmo_last = {{(TMO_W-1){1'b1}}, 1'b0};

    logic [DR_W-1:0]  r_dr;
    logic [DR_W-1:0]  w_status;
    logic [2:0]       w_sel_in;
    logic [2:0]       w_sel_raw;
    logic [2:0]       w_sel_s;
    logic             w_upd;
    logic             w_upd_go;
    logic             w_upd_abort;
    logic [2:0]       w_req_dom;
    logic [3:0]       w_req_cnt;
    logic             w_req_ok;

    nstep_state_e     r_state, w_state_nx;
    logic             r_vld, w_vld_nx;
    logic [3:0]       r_count, w_count_nx;
    logic [2:0]       r_domain, w_domain_nx;
    logic             r_done, w_done_nx;
    logic             r_timeout, w_timeout_nx;
    logic             r_err, w_err_nx;
    logic [TMO_W-1:0] r_tmo, w_tmo_nx;

    assign w_sel_in[c_dom_cmp]  = cmp_nstep_sel;
    assign w_sel_in[c_dom_dram] = dram_nstep_sel;
    assign w_sel_in[c_dom_jbus] = jbus_nstep_sel;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            ctu_nstep_sync #(.STAGES(SYNC_STAGES)) u_sync (
                .clk (clk),
                .rst (rst),
                .d   (w_sel_in[gi]),
                .q   (w_sel_raw[gi])
            );
        end
    endgenerate

    // Only domains named in the accepted request take part in the handshake
    assign w_sel_s    = w_sel_raw & r_domain;
    assign nstep_busy = is_busy(r_state);
    assign w_status   = {nstep_busy, r_done, r_timeout, r_err, w_sel_raw, r_state};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dr <= '0;
        end else if (tap.capture_dr && tap.sel_nstep) begin
            r_dr <= w_status;
        end else if (tap.shift_dr && tap.sel_nstep) begin
            r_dr <= {tap.tdi, r_dr[DR_W-1:1]};
        end
    end

    assign tap.tdo = r_dr[0];

    assign w_upd       = tap.update_dr & tap.sel_nstep;
    assign w_upd_abort = w_upd & r_dr[c_dr_abort];
    assign w_upd_go    = w_upd & r_dr[c_dr_go] & ~r_dr[c_dr_abort];
    assign w_req_dom   = r_dr[c_dr_dom_hi:c_dr_dom_lo];
    assign w_req_cnt   = r_dr[c_dr_cnt_hi:c_dr_cnt_lo];
    assign w_req_ok    = (w_req_cnt != 4'd0) && (w_req_dom != 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_vld     <= 1'b0;
            r_count   <= '0;
            r_domain  <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_err     <= 1'b0;
            r_tmo     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_vld     <= w_vld_nx;
            r_count   <= w_count_nx;
            r_domain  <= w_domain_nx;
            r_done    <= w_done_nx;
            r_timeout <= w_timeout_nx;
            r_err     <= w_err_nx;
            r_tmo     <= w_tmo_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_vld_nx     = r_vld;
        w_count_nx   = r_count;
        w_domain_nx  = r_domain;
        w_done_nx    = r_done;
        w_timeout_nx = r_timeout;
        w_err_nx     = r_err;
        w_tmo_nx     = r_tmo;

        if (w_upd_abort && (r_state != ST_IDLE)) begin
            w_state_nx   = ST_IDLE;
            w_vld_nx     = 1'b0;
            w_done_nx    = 1'b0;
            w_timeout_nx = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_upd_go) begin
                        if (w_req_ok) begin
                            w_count_nx   = w_req_cnt;
                            w_domain_nx  = w_req_dom;
                            w_done_nx    = 1'b0;
                            w_timeout_nx = 1'b0;
                            w_err_nx     = 1'b0;
                            w_state_nx   = ST_ARM;
                        end else begin
                            w_err_nx   = 1'b1;
                            w_state_nx = ST_IDLE;
                        end
                    end
                end
                ST_ARM: begin
                    w_vld_nx   = 1'b1;
                    w_state_nx = ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (w_sel_s != 3'd0) begin
                        w_vld_nx   = 1'b0;
                        w_state_nx = ST_WAIT_DONE;
                    end else if (r_tmo == c_tmo_last) begin
                        w_vld_nx     = 1'b0;
                        w_timeout_nx = 1'b1;
                        w_state_nx   = ST_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (w_sel_s == 3'd0) begin
                        w_done_nx  = 1'b1;
                        w_state_nx = ST_DONE;
                    end else if (r_tmo == c_tmo_last) begin
                        w_timeout_nx = 1'b1;
                        w_state_nx   = ST_DONE;
                    end
                end
                default: begin
                    w_vld_nx   = 1'b0;
                    w_state_nx = ST_IDLE;
                end
            endcase

            if (w_upd_go && nstep_busy) begin
                w_err_nx = 1'b1;
            end
        end

        // The counter expires on the edge it would reach all-ones, giving 2**TMO_W-1 cycles per phase
        if (w_state_nx != r_state) begin
            w_tmo_nx = '0;
        end else if (((r_state == ST_WAIT_START) || (r_state == ST_WAIT_DONE)) && (r_tmo != c_tmo_max)) begin
            w_tmo_nx = r_tmo + 1'b1;
        end
    end

    assign jtag_nstep_vld    = r_vld;
    assign jtag_nstep_count  = r_count;
    assign jtag_nstep_domain = r_domain;

endmodule
`default_nettype wire

// File: tb/tb_ctu_jtag_nstep_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctu_jtag_nstep_ctl
//  Description : Self-checking bench for the JTAG n-step controller.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ctu_jtag_nstep_ctl;

    localparam int c_sync  = 2;
    localparam int c_tmo_w = 12;
    localparam int c_tmo_cycles = (1 << c_tmo_w) - 1;
    // A sel change is visible to the controller after c_sync flops plus one state edge
    localparam int c_sel_lat = c_sync + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmp_sel = 1'b0;
    logic       dram_sel = 1'b0;
    logic       jbus_sel = 1'b0;
    logic [3:0] count;
    logic [2:0] domain;
    logic       vld;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    ctu_jtag_nstep_ctl_if tap ();

    ctu_jtag_nstep_ctl #(
        .DR_W        (10),
        .SYNC_STAGES (c_sync),
        .TMO_W       (c_tmo_w)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .tap               (tap),
        .cmp_nstep_sel     (cmp_sel),
        .dram_nstep_sel    (dram_sel),
        .jbus_nstep_sel    (jbus_sel),
        .jtag_nstep_count  (count),
        .jtag_nstep_domain (domain),
        .jtag_nstep_vld    (vld),
        .nstep_busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] mk_word(input logic go, input logic abort,
                                           input logic [2:0] dom, input logic [3:0] cnt,
                                           input logic rsvd);
        return {go, abort, dom, cnt, rsvd};
    endfunction

    function automatic logic [9:0] exp_status(input logic b, input logic d, input logic t,
                                              input logic e, input logic [2:0] sel,
                                              input logic [2:0] st);
        return {b, d, t, e, sel, st};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        #4;
        rst = 1'b0;
        step();
    endtask

    // Capture, shift w in LSB first, optionally pulse update; returns the captured status
    task automatic shift_word(input logic [9:0] w, input bit do_update, output logic [9:0] cap);
        tap.sel_nstep  = 1'b1;
        tap.capture_dr = 1'b1;
        step();
        tap.capture_dr = 1'b0;
        tap.shift_dr   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cap[i]  = tap.tdo;
            tap.tdi = w[i];
            step();
        end
        tap.shift_dr = 1'b0;
        tap.tdi      = 1'b0;
        if (do_update) begin
            tap.update_dr = 1'b1;
            step();
            tap.update_dr = 1'b0;
        end
        tap.sel_nstep = 1'b0;
    endtask

    task automatic wait_level(input bit use_busy, input logic level, input int max_cyc,
                              output int cyc, output bit ok);
        cyc = 0;
        while (((use_busy ? busy : vld) !== level) && (cyc < max_cyc)) begin
            step();
            cyc++;
        end
        ok = ((use_busy ? busy : vld) === level);
    endtask

    task automatic test_reset();
        logic [9:0] cap;
        apply_reset();
        n_checks++; if (vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got=%b exp=0", vld); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++; if (domain !== 3'd0) begin n_fail++; $display("FAIL reset_domain got=%b exp=000", domain); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (tap.tdo !== 1'b0) begin n_fail++; $display("FAIL reset_tdo got=%b exp=0", tap.tdo); end
        shift_word(10'h000, 1'b0, cap);
        n_checks++; if (cap !== 10'h000) begin n_fail++; $display("FAIL reset_capture got=%h exp=000", cap); end
    endtask

    task automatic test_single_step();
        logic [9:0] cap;
        int cyc;
        bit ok;
        shift_word(mk_word(1'b1, 1'b0, 3'b001, 4'd5, 1'b0), 1'b1, cap);
        wait_level(1'b0, 1'b1, 10, cyc, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_vld_rise got=%b exp=1", vld); end
        n_checks++; if (count !== 4'd5 || domain !== 3'b001) begin
            n_fail++; $display("FAIL single_req got=%0d/%b exp=5/001", count, domain); end
        repeat (4) step();
        cmp_sel = 1'b1;
        wait_level(1'b0, 1'b0, 20, cyc, ok);
        n_checks++; if (cyc != c_sel_lat) begin n_fail++; $display("FAIL single_vld_hold got=%0d exp=%0d", cyc, c_sel_lat); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_wait got=%b exp=1", busy); end
        repeat (20 - cyc) step();
        cmp_sel = 1'b0;
        wait_level(1'b1, 1'b0, 20, cyc, ok);
        n_checks++; if (cyc != c_sel_lat) begin n_fail++; $display("FAIL single_done_lat got=%0d exp=%0d", cyc, c_sel_lat); end
        shift_word(10'h000, 1'b0, cap);
        n_checks++; if (cap !== exp_status(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'd4)) begin
            n_fail++; $display("FAIL single_capture got=%h exp=%h", cap, exp_status(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'd4)); end
        n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL single_count_hold got=%0d exp=5", count); end
    endtask

    task automatic test_zero_count();
        logic [9:0] cap;
        logic [9:0] exp_cap;
        exp_cap = exp_status(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'd0);
        for (int k = 0; k < 2; k++) begin
            apply_reset();
            if (k == 0) shift_word(mk_word(1'b1, 1'b0, 3'($urandom_range(1, 7)), 4'd0, 1'b0), 1'b1, cap);
            else        shift_word(mk_word(1'b1, 1'b0, 3'd0, 4'($urandom_range(1, 15)), 1'b0), 1'b1, cap);
            repeat (3) step();
            n_checks++; if (vld !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL zero_req_vld k=%0d got=%b%b exp=00", k, vld, busy); end
            shift_word(10'h000, 1'b0, cap);
            n_checks++; if (cap !== exp_cap) begin n_fail++; $display("FAIL zero_req_capture k=%0d got=%h exp=%h", k, cap, exp_cap); end
        end
    endtask

    task automatic test_multi_domain();
        logic [9:0] cap;
        logic [3:0] cnt;
        int cyc;
        bit ok;
        cnt = 4'($urandom_range(1, 15));
        shift_word(mk_word(1'b1, 1'b0, 3'b111, cnt, 1'b0), 1'b1, cap);
        wait_level(1'b0, 1'b1, 10, cyc, ok);
        n_checks++; if (!ok || domain !== 3'b111 || count !== cnt) begin
            n_fail++; $display("FAIL multi_req got=%b/%b/%0d exp=1/111/%0d", vld, domain, count, cnt); end
        repeat ($urandom_range(0, 3)) step();
        cmp_sel = 1'b1; dram_sel = 1'b1; jbus_sel = 1'b1;
        wait_level(1'b0, 1'b0, 20, cyc, ok);
        n_checks++; if (cyc != c_sel_lat) begin n_fail++; $display("FAIL multi_vld_hold got=%0d exp=%0d", cyc, c_sel_lat); end
        repeat (5) step();
        cmp_sel = 1'b0; jbus_sel = 1'b0;
        repeat (c_sync + 4) step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL multi_dram_pending got=%b exp=1", busy); end
        dram_sel = 1'b0;
        wait_level(1'b1, 1'b0, 20, cyc, ok);
        n_checks++; if (cyc != c_sel_lat) begin n_fail++; $display("FAIL multi_done_lat got=%0d exp=%0d", cyc, c_sel_lat); end
        shift_word(10'h000, 1'b0, cap);
        n_checks++; if (cap !== exp_status(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'd4)) begin
            n_fail++; $display("FAIL multi_capture got=%h exp=%h", cap, exp_status(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'd4)); end
    endtask

    task automatic test_timeout();
        logic [9:0] cap;
        int cyc;
        bit ok;
        shift_word(mk_word(1'b1, 1'b0, 3'($urandom_range(1, 7)), 4'($urandom_range(1, 15)), 1'b0), 1'b1, cap);
        wait_level(1'b0, 1'b1, 10, cyc, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo_vld_rise got=%b exp=1", vld); end
        wait_level(1'b0, 1'b0, c_tmo_cycles + 100, cyc, ok);
        n_checks++; if (cyc != c_tmo_cycles) begin n_fail++; $display("FAIL tmo_cycles got=%0d exp=%0d", cyc, c_tmo_cycles); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy got=%b exp=0", busy); end
        shift_word(10'h000, 1'b0, cap);
        n_checks++; if (cap !== exp_status(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'd4)) begin
            n_fail++; $display("FAIL tmo_capture got=%h exp=%h", cap, exp_status(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'd4)); end
    endtask

    task automatic test_abort();
        logic [9:0] cap;
        logic [3:0] cnt;
        logic [2:0] dom;
        int cyc;
        bit ok;
        shift_word(mk_word(1'b1, 1'b0, 3'b010, 4'($urandom_range(1, 15)), 1'b0), 1'b1, cap);
        wait_level(1'b0, 1'b1, 10, cyc, ok);
        dram_sel = 1'b1;
        wait_level(1'b0, 1'b0, 20, cyc, ok);
        n_checks++; if (!ok || busy !== 1'b1) begin n_fail++; $display("FAIL abort_in_wait got=%b%b exp=01", vld, busy); end
        shift_word(mk_word(1'($urandom_range(0, 1)), 1'b1, 3'($urandom), 4'($urandom), 1'b0), 1'b1, cap);
        n_checks++; if (vld !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_exit got=%b%b exp=00", vld, busy); end
        dram_sel = 1'b0;
        repeat (c_sel_lat) step();
        shift_word(10'h000, 1'b0, cap);
        n_checks++; if (cap !== 10'h000) begin n_fail++; $display("FAIL abort_capture got=%h exp=000", cap); end
        cnt = 4'($urandom_range(1, 15));
        dom = 3'($urandom_range(1, 7));
        shift_word(mk_word(1'b1, 1'b0, dom, cnt, 1'b0), 1'b1, cap);
        wait_level(1'b0, 1'b1, 10, cyc, ok);
        n_checks++; if (!ok || count !== cnt || domain !== dom) begin
            n_fail++; $display("FAIL abort_retry_req got=%b/%0d/%b exp=1/%0d/%b", vld, count, domain, cnt, dom); end
        cmp_sel = dom[0]; dram_sel = dom[1]; jbus_sel = dom[2];
        wait_level(1'b0, 1'b0, 20, cyc, ok);
        repeat (3) step();
        cmp_sel = 1'b0; dram_sel = 1'b0; jbus_sel = 1'b0;
        wait_level(1'b1, 1'b0, 20, cyc, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_retry_done got=%b exp=0", busy); end
        shift_word(10'h000, 1'b0, cap);
        n_checks++; if (cap !== exp_status(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'd4)) begin
            n_fail++; $display("FAIL abort_retry_capture got=%h exp=%h", cap, exp_status(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'd4)); end
    endtask

    task automatic test_reset_busy();
        logic [9:0] cap;
        logic [3:0] cnt;
        int cyc;
        bit ok;
        cnt = 4'($urandom_range(1, 15));
        shift_word(mk_word(1'b1, 1'b0, 3'($urandom_range(1, 7)), cnt, 1'b0), 1'b1, cap);
        wait_level(1'b0, 1'b1, 10, cyc, ok);
        shift_word(mk_word(1'b1, 1'b0, 3'($urandom_range(1, 7)), cnt + 4'd1, 1'b1), 1'b1, cap);
        n_checks++; if (vld !== 1'b1 || count !== cnt) begin
            n_fail++; $display("FAIL busy_go_ignored got=%b/%0d exp=1/%0d", vld, count, cnt); end
        shift_word(10'h001, 1'b0, cap);
        n_checks++; if (cap !== exp_status(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 3'd2)) begin
            n_fail++; $display("FAIL busy_go_err got=%h exp=%h", cap, exp_status(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 3'd2)); end
        n_checks++; if (tap.tdo !== 1'b1) begin n_fail++; $display("FAIL busy_tdo_pre got=%b exp=1", tap.tdo); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (vld !== 1'b0 || count !== 4'd0 || domain !== 3'd0 || tap.tdo !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got=%b/%0d/%b/%b/%b exp=0/0/000/0/0", vld, count, domain, tap.tdo, busy); end
        #1;
        rst = 1'b0;
        step();
        shift_word(10'h000, 1'b0, cap);
        n_checks++; if (cap !== 10'h000) begin n_fail++; $display("FAIL async_reset_capture got=%h exp=000", cap); end
    endtask

    initial begin
        tap.sel_nstep  = 1'b0;
        tap.capture_dr = 1'b0;
        tap.shift_dr   = 1'b0;
        tap.update_dr  = 1'b0;
        tap.tdi        = 1'b0;
        test_reset();
        test_single_step();
        test_zero_count();
        test_multi_domain();
        test_timeout();
        test_abort();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
